// File: rtl/apb4_reg_bridge_pkg.sv
// Shared types and helpers for the APB4-to-register-block bridge.
// Widths derived from DATA_WIDTH are exposed as functions so each instance computes its own.
package apb4_reg_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } bridge_state_t;

  // Widest legal data bus; strb_to_biten works at this width and callers truncate.
  localparam int MAX_DATA_WIDTH = 64;
  localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int align_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic logic [MAX_DATA_WIDTH-1:0] strb_to_biten(
    input logic [MAX_STRB_WIDTH-1:0] strb
  );
    logic [MAX_DATA_WIDTH-1:0] biten;
    biten = '0;
    for (int i = 0; i < MAX_STRB_WIDTH; i++) begin
      biten[8*i +: 8] = {8{strb[i]}};
    end
    return biten;
  endfunction

endpackage

// File: rtl/apb4_timeout_ctr.sv
// Cycle counter for the REQ/WAIT phases of a transfer; expired flags the last allowed cycle.
// TIMEOUT_CYCLES == 0 removes the counter entirely.
module apb4_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_disabled
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, clear, run};
    assign expired       = 1'b0;
  end else begin : g_enabled
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count <= '0;
      end else if (clear) begin
        count <= '0;
      end else if (run && count != LAST) begin
        count <= count + CW'(1);
      end
    end

    assign expired = run && (count == LAST);
  end

endmodule

// File: rtl/apb4_reg_bridge.sv
// APB4 completer that turns each transfer into one request on the register-block CPU bus
// and returns the block's ack, error and read data; all outputs are registered.
module apb4_reg_bridge
  import apb4_reg_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_SPAN       = 256,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDR_WIDTH-1:0]     paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  output logic                      pready,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pslverr,
  output logic                      bus_req,
  output logic                      bus_req_is_wr,
  output logic [ADDR_WIDTH-1:0]     bus_addr,
  output logic [DATA_WIDTH-1:0]     bus_wr_data,
  output logic [DATA_WIDTH-1:0]     bus_wr_biten,
  input  logic                      bus_req_stall_wr,
  input  logic                      bus_req_stall_rd,
  input  logic                      bus_rd_ack,
  input  logic                      bus_rd_err,
  input  logic [DATA_WIDTH-1:0]     bus_rd_data,
  input  logic                      bus_wr_ack,
  input  logic                      bus_wr_err
);

  localparam int STRB_WIDTH = strb_width(DATA_WIDTH);
  localparam int ALIGN_BITS = align_bits(DATA_WIDTH);
  localparam logic [63:0] ALIGN_MASK = (64'd1 << ALIGN_BITS) - 64'd1;

  bridge_state_t         state;
  logic                  aborted;
  logic                  timed_out;
  logic                  ctr_clear;
  logic                  ctr_run;
  logic                  setup_err;
  logic [DATA_WIDTH-1:0] setup_biten;
  logic                  cur_stall;
  logic                  cur_ack;
  logic                  cur_err;
  logic [DATA_WIDTH-1:0] cur_rdata;

  // Address checks are done on a 64-bit copy so any ADDR_WIDTH/REG_SPAN pairing compares cleanly.
  assign setup_err   = (64'(paddr) >= 64'(REG_SPAN)) || ((64'(paddr) & ALIGN_MASK) != 64'd0);
  assign setup_biten = DATA_WIDTH'(strb_to_biten(MAX_STRB_WIDTH'(pstrb)));

  // NOTE: every signal written in always_comb is given a value on every path, so no latch is inferred.
  always_comb begin
    cur_stall = bus_req_stall_rd;
    cur_ack   = bus_rd_ack;
    cur_err   = bus_rd_err;
    cur_rdata = bus_rd_data;
    if (bus_req_is_wr) begin
      cur_stall = bus_req_stall_wr;
      cur_ack   = bus_wr_ack;
      cur_err   = bus_wr_err;
      cur_rdata = '0;
    end
  end

  assign ctr_clear = (state == IDLE);
  assign ctr_run   = (state == REQ) || (state == WAIT);

  apb4_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (ctr_clear),
    .run    (ctr_run),
    .expired(timed_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      aborted       <= 1'b0;
      pready        <= 1'b0;
      prdata        <= '0;
      pslverr       <= 1'b0;
      bus_req       <= 1'b0;
      bus_req_is_wr <= 1'b0;
      bus_addr      <= '0;
      bus_wr_data   <= '0;
      bus_wr_biten  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so each register samples pre-edge values;
      // these defaults make the APB response a one-cycle pulse that is zero otherwise.
      pready  <= 1'b0;
      prdata  <= '0;
      pslverr <= 1'b0;

      unique case (state)
        IDLE: begin
          aborted <= 1'b0;
          if (psel && !penable) begin
            bus_req_is_wr <= pwrite;
            bus_addr      <= paddr;
            bus_wr_data   <= pwdata;
            bus_wr_biten  <= setup_biten;
            if (setup_err || (pwrite && pstrb == '0)) begin
              state   <= RESP;
              pready  <= 1'b1;
              pslverr <= setup_err;
            end else begin
              state   <= REQ;
              bus_req <= 1'b1;
            end
          end
        end

        REQ: begin
          if (!psel) begin
            state   <= IDLE;
            bus_req <= 1'b0;
          end else if (!cur_stall && cur_ack) begin
            state   <= RESP;
            bus_req <= 1'b0;
            pready  <= 1'b1;
            prdata  <= cur_rdata;
            pslverr <= cur_err;
          end else if (timed_out) begin
            state   <= RESP;
            bus_req <= 1'b0;
            pready  <= 1'b1;
            pslverr <= 1'b1;
          end else if (!cur_stall) begin
            state   <= WAIT;
            bus_req <= 1'b0;
          end
        end

        WAIT: begin
          // An ack in the same cycle as expiry still wins; a dropped psel only suppresses pready.
          if (cur_ack || timed_out) begin
            if (aborted || !psel) begin
              state <= IDLE;
            end else begin
              state   <= RESP;
              pready  <= 1'b1;
              prdata  <= cur_ack ? cur_rdata : '0;
              pslverr <= cur_ack ? cur_err : 1'b1;
            end
          end else if (!psel) begin
            aborted <= 1'b1;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_reg_bridge.sv
// Self-checking bench for apb4_reg_bridge: directed scenarios plus randomized transfers
// compared against a cycle-count model derived from the transfer rules.
module tb_apb4_reg_bridge;

  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int SPAN = 256;
  localparam int TO   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0;
  logic [SW-1:0] pstrb = '0;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;
  logic          bus_req;
  logic          bus_req_is_wr;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wr_data;
  logic [DW-1:0] bus_wr_biten;
  logic          bus_req_stall_wr = 1'b0;
  logic          bus_req_stall_rd = 1'b0;
  logic          bus_rd_ack = 1'b0;
  logic          bus_rd_err = 1'b0;
  logic [DW-1:0] bus_rd_data = '0;
  logic          bus_wr_ack = 1'b0;
  logic          bus_wr_err = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  apb4_reg_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_SPAN(SPAN), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
    .pslverr(pslverr), .bus_req(bus_req), .bus_req_is_wr(bus_req_is_wr),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_wr_biten(bus_wr_biten),
    .bus_req_stall_wr(bus_req_stall_wr), .bus_req_stall_rd(bus_req_stall_rd),
    .bus_rd_ack(bus_rd_ack), .bus_rd_err(bus_rd_err), .bus_rd_data(bus_rd_data),
    .bus_wr_ack(bus_wr_ack), .bus_wr_err(bus_wr_err)
  );

  // ready_n counts cycles after the setup edge: 0 means pready in the very next cycle.
  typedef struct {
    int            ready_n;
    logic [DW-1:0] rdata;
    logic          err;
    int            req_cycles;
    int            accepts;
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] biten;
    bit            clean;
  } obs_t;

  typedef struct {
    int            ready_n;
    logic [DW-1:0] rdata;
    logic          err;
    int            req_cycles;
    int            accepts;
  } exp_t;

  function automatic exp_t predict(input logic wr, input logic [AW-1:0] addr,
                                   input logic [SW-1:0] strb, input int stall,
                                   input int ack_delay, input logic [DW-1:0] rd,
                                   input logic e);
    exp_t x;
    int   a;
    int   ack_idx;
    x = '{ready_n: 0, rdata: '0, err: 1'b0, req_cycles: 0, accepts: 0};
    a = int'(addr);
    if (a >= SPAN || (a % SW) != 0) begin
      x.err = 1'b1;
    end else if (!(wr && strb == '0)) begin
      ack_idx = (ack_delay < 0) ? 1000 : stall + ack_delay;
      if (ack_idx < TO) begin
        x.ready_n    = ack_idx + 1;
        x.err        = e;
        x.rdata      = wr ? '0 : rd;
        x.req_cycles = stall + 1;
        x.accepts    = 1;
      end else begin
        x.ready_n    = TO;
        x.err        = 1'b1;
        x.req_cycles = (stall + 1 < TO) ? stall + 1 : TO;
        x.accepts    = (stall < TO) ? 1 : 0;
      end
    end
    return x;
  endfunction

  function automatic logic [DW-1:0] expand(input logic [SW-1:0] s);
    logic [DW-1:0] b;
    b = '0;
    for (int i = 0; i < SW; i++) if (s[i]) b = b | (DW'(32'hFF) << (8 * i));
    return b;
  endfunction

  // Drives one APB transfer and plays the register block; stall holds the first `stall`
  // request cycles, the ack comes `ack_delay` cycles after acceptance (-1: never).
  task automatic run_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [SW-1:0] strb, input int stall, input int ack_delay,
                          input logic [DW-1:0] rd, input logic e, input bit b2b,
                          output obs_t o);
    int   acc_n;
    logic stall_now;
    logic ack_now;
    o = '{default: 0};
    o.ready_n = -1;
    o.clean   = 1'b1;
    acc_n     = -1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb;
    @(posedge clk);
    for (int n = 0; n < 48; n++) begin
      @(negedge clk);
      penable = 1'b1;
      if (bus_req === 1'b1) begin
        if (o.req_cycles == 0) begin
          o.is_wr = bus_req_is_wr; o.addr = bus_addr;
          o.wdata = bus_wr_data;   o.biten = bus_wr_biten;
        end
        stall_now = (o.req_cycles < stall);
        o.req_cycles++;
        if (!stall_now) begin
          o.accepts++;
          acc_n = n;
        end
      end else begin
        stall_now = 1'($urandom_range(0, 1));
      end
      ack_now = (acc_n >= 0) && (ack_delay >= 0) && (n == acc_n + ack_delay);
      if (wr) begin
        bus_req_stall_wr = stall_now;
        bus_req_stall_rd = 1'($urandom_range(0, 1));
        bus_wr_ack  = ack_now;
        bus_wr_err  = ack_now ? e : 1'($urandom_range(0, 1));
        bus_rd_ack  = 1'($urandom_range(0, 1));
        bus_rd_err  = 1'($urandom_range(0, 1));
        bus_rd_data = $urandom;
      end else begin
        bus_req_stall_rd = stall_now;
        bus_req_stall_wr = 1'($urandom_range(0, 1));
        bus_rd_ack  = ack_now;
        bus_rd_err  = ack_now ? e : 1'($urandom_range(0, 1));
        bus_rd_data = ack_now ? rd : $urandom;
        bus_wr_ack  = 1'($urandom_range(0, 1));
        bus_wr_err  = 1'($urandom_range(0, 1));
      end
      if (pready === 1'b1) begin
        o.ready_n = n;
        o.rdata   = prdata;
        o.err     = pslverr;
        break;
      end
      if (prdata !== '0 || pslverr !== 1'b0) o.clean = 1'b0;
    end
    @(posedge clk);
    #1;
    penable = 1'b0;
    psel    = b2b;
    bus_req_stall_wr = 1'b0; bus_req_stall_rd = 1'b0;
    bus_rd_ack = 1'b0; bus_rd_err = 1'b0; bus_wr_ack = 1'b0; bus_wr_err = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({pready, pslverr, prdata, bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: pready=%b pslverr=%b prdata=%h bus_req=%b addr=%h", pready, pslverr, prdata, bus_req, bus_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_zero_wait;
    obs_t o;
    run_xfer(1'b1, 12'h010, 32'hDEADBEEF, 4'b0101, 0, 0, '0, 1'b0, 1'b0, o);
    n_cmp++; if (o.ready_n !== 1) begin n_bad++; $display("FAIL wr0_latency: got %0d expected 1", o.ready_n); end
    n_cmp++; if (o.req_cycles !== 1) begin n_bad++; $display("FAIL wr0_req_cycles: got %0d expected 1", o.req_cycles); end
    n_cmp++; if (o.addr !== 12'h010 || o.is_wr !== 1'b1) begin n_bad++; $display("FAIL wr0_addr: got %h/%b expected 010/1", o.addr, o.is_wr); end
    n_cmp++; if (o.biten !== 32'h00FF00FF) begin n_bad++; $display("FAIL wr0_biten: got %h expected 00ff00ff", o.biten); end
    n_cmp++; if (o.wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr0_wdata: got %h expected deadbeef", o.wdata); end
    n_cmp++; if (o.err !== 1'b0 || o.rdata !== '0) begin n_bad++; $display("FAIL wr0_resp: got err=%b rdata=%h expected 0/0", o.err, o.rdata); end
  endtask

  task automatic test_read_wait;
    obs_t o;
    run_xfer(1'b0, 12'h020, 32'h0, 4'hF, 0, 3, 32'h12345678, 1'b0, 1'b0, o);
    n_cmp++; if (o.ready_n !== 4) begin n_bad++; $display("FAIL rd_latency: got %0d expected 4", o.ready_n); end
    n_cmp++; if (o.rdata !== 32'h12345678 || o.err !== 1'b0) begin n_bad++; $display("FAIL rd_data: got %h/%b expected 12345678/0", o.rdata, o.err); end
    n_cmp++; if (o.clean !== 1'b1) begin n_bad++; $display("FAIL rd_idle_zero: got %b expected 1", o.clean); end
  endtask

  task automatic test_stall;
    obs_t o;
    run_xfer(1'b1, 12'h0F0, 32'hA1B2C3D4, 4'hF, 2, 0, '0, 1'b0, 1'b0, o);
    n_cmp++; if (o.req_cycles !== 3) begin n_bad++; $display("FAIL stall_req_cycles: got %0d expected 3", o.req_cycles); end
    n_cmp++; if (o.accepts !== 1) begin n_bad++; $display("FAIL stall_accepts: got %0d expected 1", o.accepts); end
    n_cmp++; if (o.ready_n !== 3 || o.err !== 1'b0) begin n_bad++; $display("FAIL stall_resp: got %0d/%b expected 3/0", o.ready_n, o.err); end
  endtask

  task automatic test_timeout;
    obs_t o;
    run_xfer(1'b0, 12'h040, 32'h0, 4'hF, 0, -1, '0, 1'b0, 1'b0, o);
    n_cmp++; if (o.ready_n !== TO) begin n_bad++; $display("FAIL to_latency: got %0d expected %0d", o.ready_n, TO); end
    n_cmp++; if (o.err !== 1'b1 || o.rdata !== '0) begin n_bad++; $display("FAIL to_resp: got err=%b rdata=%h expected 1/0", o.err, o.rdata); end
    n_cmp++; if (o.req_cycles !== 1) begin n_bad++; $display("FAIL to_req_cycles: got %0d expected 1", o.req_cycles); end
    @(negedge clk);
    bus_rd_ack = 1'b1; bus_rd_err = 1'b1; bus_rd_data = 32'hBAD0BAD0;
    @(negedge clk);
    bus_rd_ack = 1'b0; bus_rd_err = 1'b0;
    n_cmp++; if (pready !== 1'b0 || bus_req !== 1'b0) begin n_bad++; $display("FAIL to_late_ack: got pready=%b bus_req=%b expected 0/0", pready, bus_req); end
    run_xfer(1'b0, 12'h044, 32'h0, 4'hF, 0, 0, 32'h600D600D, 1'b0, 1'b0, o);
    n_cmp++; if (o.ready_n !== 1 || o.rdata !== 32'h600D600D || o.err !== 1'b0) begin
      n_bad++; $display("FAIL to_next_xfer: got %0d/%h/%b expected 1/600d600d/0", o.ready_n, o.rdata, o.err);
    end
  endtask

  task automatic test_errors;
    obs_t o;
    run_xfer(1'b0, 12'h002, 32'h0, 4'hF, 0, 0, 32'h11111111, 1'b0, 1'b0, o);
    n_cmp++; if (o.ready_n !== 0 || o.err !== 1'b1 || o.req_cycles !== 0 || o.rdata !== '0) begin
      n_bad++; $display("FAIL misaligned: got %0d/%b/%0d/%h expected 0/1/0/0", o.ready_n, o.err, o.req_cycles, o.rdata);
    end
    run_xfer(1'b1, 12'h100, 32'h5, 4'hF, 0, 0, '0, 1'b0, 1'b0, o);
    n_cmp++; if (o.ready_n !== 0 || o.err !== 1'b1 || o.req_cycles !== 0) begin
      n_bad++; $display("FAIL out_of_range: got %0d/%b/%0d expected 0/1/0", o.ready_n, o.err, o.req_cycles);
    end
    run_xfer(1'b1, 12'h0FC, 32'h5, 4'h0, 0, 0, '0, 1'b0, 1'b0, o);
    n_cmp++; if (o.ready_n !== 0 || o.err !== 1'b0 || o.req_cycles !== 0) begin
      n_bad++; $display("FAIL zero_strobe: got %0d/%b/%0d expected 0/0/0", o.ready_n, o.err, o.req_cycles);
    end
  endtask

  task automatic test_abort;
    int seen;
    seen = 0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h030; pwdata = 32'h11112222; pstrb = 4'hF;
    bus_req_stall_wr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    penable = 1'b1;
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL abort_req_up: got %b expected 1", bus_req); end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus_req !== 1'b0 || pready !== 1'b0) begin n_bad++; $display("FAIL abort_drop: got bus_req=%b pready=%b expected 0/0", bus_req, pready); end
    repeat (3) begin
      @(negedge clk);
      if (pready === 1'b1) seen++;
    end
    bus_req_stall_wr = 1'b0;
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL abort_no_pready: got %0d pready cycles expected 0", seen); end
  endtask

  task automatic test_reset_mid_wait;
    obs_t o;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h008; pwdata = 32'hA5A50F0F; pstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({pready, pslverr, prdata, bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_wait: got addr=%h wdata=%h biten=%h bus_req=%b expected all 0", bus_addr, bus_wr_data, bus_wr_biten, bus_req);
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus_rd_ack = 1'b1; bus_rd_data = 32'hDEAD0000;
    @(negedge clk);
    bus_rd_ack = 1'b0;
    @(negedge clk);
    n_cmp++; if (pready !== 1'b0 || bus_req !== 1'b0) begin n_bad++; $display("FAIL stale_ack: got pready=%b bus_req=%b expected 0/0", pready, bus_req); end
    run_xfer(1'b0, 12'h004, 32'h0, 4'hF, 0, 1, 32'hCAFE0004, 1'b0, 1'b0, o);
    n_cmp++; if (o.ready_n !== 2 || o.rdata !== 32'hCAFE0004 || o.err !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_read: got %0d/%h/%b expected 2/cafe0004/0", o.ready_n, o.rdata, o.err);
    end
  endtask

  task automatic test_back_to_back;
    obs_t o1;
    obs_t o2;
    run_xfer(1'b1, 12'h050, 32'h01020304, 4'hF, 0, 0, '0, 1'b1, 1'b1, o1);
    run_xfer(1'b0, 12'h054, 32'h0, 4'hF, 0, 0, 32'h0BADF00D, 1'b0, 1'b0, o2);
    n_cmp++; if (o1.ready_n !== 1 || o1.err !== 1'b1) begin n_bad++; $display("FAIL b2b_first: got %0d/%b expected 1/1", o1.ready_n, o1.err); end
    n_cmp++; if (o2.ready_n !== 1 || o2.rdata !== 32'h0BADF00D || o2.addr !== 12'h054) begin
      n_bad++; $display("FAIL b2b_second: got %0d/%h/%h expected 1/0badf00d/054", o2.ready_n, o2.rdata, o2.addr);
    end
  endtask

  task automatic test_random;
    obs_t o;
    exp_t x;
    for (int i = 0; i < 40; i++) begin
      logic          wr;
      logic [AW-1:0] addr;
      logic [SW-1:0] strb;
      logic [DW-1:0] wd;
      logic [DW-1:0] rd;
      logic          e;
      int            stall;
      int            ad;
      bit            b2b;
      wr    = 1'($urandom_range(0, 1));
      addr  = AW'($urandom_range(0, 'h13F));
      if ($urandom_range(0, 4) != 0) addr[1:0] = 2'b00;
      strb  = SW'($urandom_range(0, 15));
      wd    = $urandom;
      rd    = $urandom;
      e     = 1'($urandom_range(0, 1));
      stall = int'($urandom_range(0, 9));
      ad    = int'($urandom_range(0, 8)) - 1;
      b2b   = (i != 39) && ($urandom_range(0, 1) == 1);
      x = predict(wr, addr, strb, stall, ad, rd, e);
      run_xfer(wr, addr, wd, strb, stall, ad, rd, e, b2b, o);
      n_cmp++; if (o.ready_n !== x.ready_n) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, o.ready_n, x.ready_n); end
      n_cmp++; if (o.err !== x.err || o.rdata !== x.rdata) begin n_bad++; $display("FAIL rnd%0d_resp: got %b/%h expected %b/%h", i, o.err, o.rdata, x.err, x.rdata); end
      n_cmp++; if (o.req_cycles !== x.req_cycles || o.accepts !== x.accepts) begin
        n_bad++; $display("FAIL rnd%0d_requests: got %0d/%0d expected %0d/%0d", i, o.req_cycles, o.accepts, x.req_cycles, x.accepts);
      end
      n_cmp++; if (o.clean !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_idle_zero: got %b expected 1", i, o.clean); end
      if (x.req_cycles > 0) begin
        n_cmp++;
        if (o.is_wr !== wr || o.addr !== addr || o.wdata !== wd || o.biten !== expand(strb)) begin
          n_bad++; $display("FAIL rnd%0d_fields: got %b/%h/%h/%h expected %b/%h/%h/%h", i, o.is_wr, o.addr, o.wdata, o.biten, wr, addr, wd, expand(strb));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_stall();
    test_timeout();
    test_errors();
    test_abort();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb4_reg_bridge.md
Name: apb4_reg_bridge

Overview:
- Parametrised APB4 completer that converts each APB transfer into exactly one single-cycle request on the register-block CPU interface bus, then waits for a read or write acknowledge.
- Adds over the previous APB slave: separate read/write ack and error, honoured stall inputs, byte-strobe to bit-enable expansion, address range/alignment checking, and a bus timeout that returns PSLVERR.
- Sits between the APB interconnect and the generated register block.

Parameters:
ADDR_WIDTH, 8, width of paddr and bus_addr (byte address)
DATA_WIDTH, 32, data width; legal values 8, 16, 32, 64
REG_SPAN, 256, bytes decoded; paddr >= REG_SPAN is an error
TIMEOUT_CYCLES, 16, max REQ+WAIT cycles before forced error; 0 disables the timeout

Ports:
clk  in  1  clock; all logic on the rising edge
rst_n  in  1  asynchronous, active-low reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB direction (1 = write)
paddr  in  ADDR_WIDTH  APB address
pwdata  in  DATA_WIDTH  APB write data
pstrb  in  DATA_WIDTH/8  APB write strobes
pready  out  1  APB ready
prdata  out  DATA_WIDTH  APB read data
pslverr  out  1  APB error
bus_req  out  1  one-cycle request to the register block
bus_req_is_wr  out  1  request direction
bus_addr  out  ADDR_WIDTH  request address
bus_wr_data  out  DATA_WIDTH  write data
bus_wr_biten  out  DATA_WIDTH  per-bit write enable
bus_req_stall_wr  in  1  register block cannot accept a write this cycle
bus_req_stall_rd  in  1  register block cannot accept a read this cycle
bus_rd_ack  in  1  read done
bus_rd_err  in  1  read error, valid with bus_rd_ack
bus_rd_data  in  DATA_WIDTH  read data, valid with bus_rd_ack
bus_wr_ack  in  1  write done
bus_wr_err  in  1  write error, valid with bus_wr_ack

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. All outputs 0. Timeout counter 0. Latched fields 0.
- All outputs are registered.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - On psel & !penable (setup phase), latch pwrite, paddr, pwdata, and the expanded strobes. Each pstrb[i] is replicated to bit-enable bits [8i+7:8i].
  - Error condition: paddr >= REG_SPAN, or paddr[log2(DATA_WIDTH/8)-1:0] != 0. On error, go to RESP with pslverr=1, prdata=0, and no bus request.
  - Write with pstrb == 0: go to RESP with pslverr=0 and no bus request.
  - Otherwise go to REQ.
- REQ:
  - bus_req=1, driven with the latched fields.
  - If the stall input for the current direction is 1: hold REQ and keep bus_req asserted.
  - Else the request is accepted this cycle. bus_req drops next cycle. If the matching ack is already present this cycle, go to RESP; otherwise go to WAIT.
- WAIT:
  - bus_req=0.
  - On the matching ack (bus_rd_ack for a read, bus_wr_ack for a write): capture bus_rd_data (reads only; writes return prdata=0) and the matching err, then go to RESP.
  - The non-matching ack is ignored.
- RESP:
  - pready=1 for exactly one cycle, with the captured prdata and pslverr. Then go to IDLE.
  - prdata and pslverr are 0 whenever pready=0.
- Timeout:
  - The counter increments every cycle in REQ or WAIT and clears in IDLE.
  - When TIMEOUT_CYCLES != 0 and the count reaches TIMEOUT_CYCLES-1 without acceptance plus ack, go to RESP with pslverr=1, prdata=0. bus_req drops.
  - Acks arriving in IDLE or RESP are ignored.
- Latency: setup at cycle T, bus_req at T+1. With a zero-wait ack at T+1, pready is at T+2, i.e. one APB wait state minimum.
- psel deasserted while in REQ (protocol abort): drop bus_req, go to IDLE, no pready.
- psel deasserted while in WAIT: continue until ack or timeout, then return to IDLE without pready.
- In IDLE, a setup phase is accepted in the cycle immediately after RESP, so back-to-back transfers are supported.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs 0. A pending register-block ack is discarded.

Decomposition:
- Package apb4_reg_bridge_pkg holds:
  - enum bridge_state_t {IDLE, REQ, WAIT, RESP};
  - function strb_to_biten;
  - localparams STRB_WIDTH = DATA_WIDTH/8 and ALIGN_BITS = $clog2(STRB_WIDTH), both provided as parameterised functions.
- One sub-module, apb4_timeout_ctr: parameter TIMEOUT_CYCLES; inputs clk, rst_n, clear, run; output expired. Counter width is $clog2(TIMEOUT_CYCLES+1). When TIMEOUT_CYCLES == 0, expired is tied to 0.

Test Plan:
- Write paddr=0x10, pwdata=0xDEADBEEF, pstrb=4'b0101; bus_wr_ack in the same cycle as bus_req -> bus_req high one cycle, bus_addr=0x10, bus_wr_biten=0x00FF00FF; pready at T+2 with pslverr=0.
- Read paddr=0x20 with bus_rd_ack 3 cycles after acceptance and bus_rd_data=0x12345678 -> pready at T+5, prdata=0x12345678, pslverr=0.
- Write with bus_req_stall_wr high for 2 cycles -> bus_req held 3 cycles, then ack; exactly one accepted request; pready with pslverr=0.
- TIMEOUT_CYCLES=8, read with no ack -> pready 8 cycles after REQ entry with pslverr=1, prdata=0; a late bus_rd_ack is ignored and the next transfer completes normally.
- Misaligned paddr=0x02 and out-of-range paddr=0x100 -> no bus_req; pready at T+1 with pslverr=1. Write with pstrb=0 -> no bus_req; pslverr=0.
- rst_n asserted in WAIT -> all outputs 0 immediately. After release, a read of 0x04 completes normally and a stale ack seen in IDLE has no effect.
